// File: rtl/lc3_ctrl_if.sv
// Control bundle between the LC-3 sequencer and the datapath/memory: IR fields in, loads/gates/selects/strobes out.
interface lc3_ctrl_if;
    logic       Run;
    logic       Continue;
    logic [3:0] Opcode;
    logic       IR_5;
    logic       IR_11;
    logic       BEN;

    logic       LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED;
    logic       GatePC, GateMDR, GateALU, GateMARMUX;
    logic       DRMUX, SR1MUX, SR2MUX, ADDR1MUX;
    logic [1:0] ADDR2MUX, PCMUX, ALUK;
    logic       MIO_EN, Mem_OE, Mem_WE;

    modport master (
        input  Run, Continue, Opcode, IR_5, IR_11, BEN,
        output LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
        output GatePC, GateMDR, GateALU, GateMARMUX,
        output DRMUX, SR1MUX, SR2MUX, ADDR1MUX, ADDR2MUX, PCMUX, ALUK,
        output MIO_EN, Mem_OE, Mem_WE
    );

    modport slave (
        output Run, Continue, Opcode, IR_5, IR_11, BEN,
        input  LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
        input  GatePC, GateMDR, GateALU, GateMARMUX,
        input  DRMUX, SR1MUX, SR2MUX, ADDR1MUX, ADDR2MUX, PCMUX, ALUK,
        input  MIO_EN, Mem_OE, Mem_WE
    );
endinterface

// File: rtl/lc3_control_unit.sv
// LC-3 subset fetch/decode/execute sequencer with memory wait states.
// Outputs are registered from the next state so they always match the current state.
module lc3_control_unit #(
    parameter int MEM_WAIT = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    lc3_ctrl_if.master  bus
);
    typedef enum logic [4:0] {
        HALTED, S18, S33, S35, S32, S01, S05, S09, S00, S22, S12, S04,
        S21, S20, S06, S25, S27, S07, S23, S16, S15, S15_LO, S15_HI
    } state_t;

    typedef struct packed {
        logic       ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led;
        logic       gate_pc, gate_mdr, gate_alu, gate_marmux;
        logic       drmux, sr1mux, sr2_en, addr1mux;
        logic [1:0] addr2mux, pcmux, aluk;
        logic       mio_en, mem_oe, mem_we;
    } ctrl_t;

    localparam logic [2:0] LAST_WAIT = 3'(MEM_WAIT - 1);

    state_t     state_q, state_d;
    logic [2:0] wait_q, wait_d;
    ctrl_t      out_q;

    function automatic ctrl_t idle_ctrl();
        ctrl_t c;
        c        = '0;
        c.mem_oe = 1'b1;
        c.mem_we = 1'b1;
        return c;
    endfunction

    function automatic ctrl_t decode(state_t s, logic last_wait);
        ctrl_t c;
        c = idle_ctrl();
        case (s)
            S18: begin c.gate_pc = 1'b1; c.ld_mar = 1'b1; c.ld_pc = 1'b1; c.pcmux = 2'b00; end
            S33, S25: begin
                c.mem_oe = 1'b0; c.mio_en = 1'b1; c.ld_mdr = last_wait;
            end
            S35: begin c.gate_mdr = 1'b1; c.ld_ir = 1'b1; end
            S32: c.ld_ben = 1'b1;
            S01, S05: begin
                c.sr2_en = 1'b1; c.aluk = (s == S05) ? 2'b01 : 2'b00;
                c.gate_alu = 1'b1; c.ld_reg = 1'b1; c.ld_cc = 1'b1; c.sr1mux = 1'b1;
            end
            S09: begin
                c.aluk = 2'b10; c.gate_alu = 1'b1; c.ld_reg = 1'b1; c.ld_cc = 1'b1; c.sr1mux = 1'b1;
            end
            S22: begin c.addr2mux = 2'b10; c.pcmux = 2'b10; c.ld_pc = 1'b1; end
            S12, S20: begin
                c.sr1mux = 1'b1; c.addr1mux = 1'b1; c.pcmux = 2'b10; c.ld_pc = 1'b1;
            end
            S04: begin c.gate_pc = 1'b1; c.drmux = 1'b1; c.ld_reg = 1'b1; end
            S21: begin c.addr2mux = 2'b11; c.pcmux = 2'b10; c.ld_pc = 1'b1; end
            S06, S07: begin
                c.sr1mux = 1'b1; c.addr1mux = 1'b1; c.addr2mux = 2'b01;
                c.gate_marmux = 1'b1; c.ld_mar = 1'b1;
            end
            S27: begin c.gate_mdr = 1'b1; c.ld_reg = 1'b1; c.ld_cc = 1'b1; end
            S23: begin c.aluk = 2'b11; c.gate_alu = 1'b1; c.ld_mdr = 1'b1; end
            S16: c.mem_we = 1'b0;
            S15: c.ld_led = 1'b1;
            default: ;
        endcase
        return c;
    endfunction

    always_comb begin
        state_d = state_q;
        wait_d  = 3'd0;
        case (state_q)
            HALTED: state_d = bus.Run ? S18 : HALTED;
            S18:    state_d = S33;
            // Memory states hold until the wait counter reaches its last cycle
            S33, S25, S16: begin
                if (wait_q == LAST_WAIT) begin
                    state_d = (state_q == S33) ? S35 : (state_q == S25) ? S27 : S18;
                end else begin
                    wait_d = wait_q + 3'd1;
                end
            end
            S35:    state_d = S32;
            S32: begin
                case (bus.Opcode)
                    4'b0001: state_d = S01;
                    4'b0101: state_d = S05;
                    4'b1001: state_d = S09;
                    4'b0000: state_d = S00;
                    4'b1100: state_d = S12;
                    4'b0100: state_d = S04;
                    4'b0110: state_d = S06;
                    4'b0111: state_d = S07;
                    4'b1101: state_d = S15;
                    default: state_d = S18;
                endcase
            end
            S00:    state_d = bus.BEN ? S22 : S18;
            S04:    state_d = bus.IR_11 ? S21 : S20;
            S06:    state_d = S25;
            S07:    state_d = S23;
            S23:    state_d = S16;
            // PAUSE always needs a full press-and-release of Continue
            S15, S15_LO: state_d = bus.Continue ? S15_HI : S15_LO;
            S15_HI: state_d = bus.Continue ? S15_HI : S18;
            default: state_d = S18;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= HALTED;
            wait_q  <= 3'd0;
            out_q   <= idle_ctrl();
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            out_q   <= decode(state_d, wait_d == LAST_WAIT);
        end
    end

    assign bus.LD_MAR     = out_q.ld_mar;
    assign bus.LD_MDR     = out_q.ld_mdr;
    assign bus.LD_IR      = out_q.ld_ir;
    assign bus.LD_BEN     = out_q.ld_ben;
    assign bus.LD_CC      = out_q.ld_cc;
    assign bus.LD_REG     = out_q.ld_reg;
    assign bus.LD_PC      = out_q.ld_pc;
    assign bus.LD_LED     = out_q.ld_led;
    assign bus.GatePC     = out_q.gate_pc;
    assign bus.GateMDR    = out_q.gate_mdr;
    assign bus.GateALU    = out_q.gate_alu;
    assign bus.GateMARMUX = out_q.gate_marmux;
    assign bus.DRMUX      = out_q.drmux;
    assign bus.SR1MUX     = out_q.sr1mux;
    assign bus.SR2MUX     = out_q.sr2_en & bus.IR_5;
    assign bus.ADDR1MUX   = out_q.addr1mux;
    assign bus.ADDR2MUX   = out_q.addr2mux;
    assign bus.PCMUX      = out_q.pcmux;
    assign bus.ALUK       = out_q.aluk;
    assign bus.MIO_EN     = out_q.mio_en;
    assign bus.Mem_OE     = out_q.mem_oe;
    assign bus.Mem_WE     = out_q.mem_we;
endmodule
